// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin sharing of one ALU between two requesters,
// with a fixed-latency result wait and a separate flag context per requester.
`default_nettype none

module alu_share_sched #(
  parameter int ALU_LAT = 1,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [2:0]    req0_op,
  input  logic [3:0]    req0_imm,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [2:0]    req1_op,
  input  logic [3:0]    req1_imm,
  output logic [DW-1:0] alu_A,
  output logic [DW-1:0] alu_B,
  output logic [2:0]    alu_op,
  output logic [3:0]    alu_imm,
  output logic [2:0]    alu_lastFlag,
  input  logic [DW-1:0] alu_out,
  input  logic [2:0]    alu_flag,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic [2:0]    rsp_flag,
  output logic [2:0]    flag0,
  output logic [2:0]    flag1,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [2:0] LAT    = 3'(ALU_LAT);

  logic [1:0] state;
  logic [2:0] cnt;
  logic       last_grant;
  logic       cur_id;
  logic       any_valid;
  logic       grant_id;
  logic       accept;

  // On a tie the requester that did not own the last completed op wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    accept    = (state == S_IDLE) & any_valid & ~rst;
  end

  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept & grant_id;
  assign rsp_valid  = (state == S_RESP);
  assign rsp_id     = cur_id;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= 3'd0;
      last_grant   <= 1'b1;
      cur_id       <= 1'b0;
      alu_A        <= '0;
      alu_B        <= '0;
      alu_op       <= 3'd0;
      alu_imm      <= 4'd0;
      alu_lastFlag <= 3'd0;
      rsp_data     <= '0;
      rsp_flag     <= 3'd0;
      flag0        <= 3'd0;
      flag1        <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            alu_A        <= grant_id ? req1_a   : req0_a;
            alu_B        <= grant_id ? req1_b   : req0_b;
            alu_op       <= grant_id ? req1_op  : req0_op;
            alu_imm      <= grant_id ? req1_imm : req0_imm;
            alu_lastFlag <= grant_id ? flag1    : flag0;
            cur_id       <= grant_id;
            cnt          <= 3'd0;
            state        <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt <= cnt + 3'd1;
          if (cnt == LAT) begin
            rsp_data <= alu_out;
            rsp_flag <= alu_flag;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            if (cur_id) flag1 <= rsp_flag;
            else        flag0 <= rsp_flag;
            last_grant <= cur_id;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
